flap_input_cond: RTL and testbench
==================================

Name: flap_input_cond

Overview:
- Input-conditioning stage that drives the flappy-bird game controller.
- Takes the raw game button pin and the VGA v_sync, and produces clean, frame-aligned control pulses for the game logic:
  - synchronised, debounced button level;
  - one-cycle frame tick at start of vertical sync;
  - one-cycle flap request, issued only on a frame tick.
- Removes metastability, bounce and mid-frame updates from the game state path.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each input synchroniser (min 2)
DEBOUNCE_CYCLES, 250000, consecutive cycles the synchronised button must hold a new level before it is accepted (10 ms at 25 MHz)
CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, 25 MHz pixel clock
rst_n  input  1  asynchronous active-low reset
button_raw  input  1  raw game button pin (ui_in[0]), active high, asynchronous, bouncy
v_sync  input  1  VGA vertical sync from the VGA timing controller, active low
button_level  output  1  debounced button level
frame_tick  output  1  one-cycle pulse at each falling edge of synchronised v_sync
flap  output  1  one-cycle flap request, coincident with frame_tick
flap_pending  output  1  a press has been captured and is waiting for the next frame_tick

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - button synchroniser = 0, button_level = 0, debounce counter = 0, pending = 0;
  - v_sync synchroniser and its edge register = 1 (idle level), so no spurious frame_tick after reset;
  - frame_tick = 0, flap = 0.
- Button synchroniser: SYNC_STAGES-deep shift register; call its output btn_s.
- Debounce counter:
  - if btn_s == button_level: counter <= 0;
  - else if counter == DEBOUNCE_CYCLES-1: button_level <= btn_s, counter <= 0;
  - else: counter <= counter+1.
  - A new level therefore appears DEBOUNCE_CYCLES cycles after btn_s first differs, provided btn_s holds for that whole span.
  - Any glitch back to the old level restarts the count from 0.
- Press edge: press = button_level rises 0->1, registered internally. Releases generate nothing.
- v_sync path: SYNC_STAGES synchroniser gives vs_s, plus one delay register vs_d.
  - frame_tick = registered (vs_d & ~vs_s): exactly one cycle per falling edge, latency SYNC_STAGES+1 cycles from the v_sync pin.
- Pending latch, evaluated per cycle in this priority:
  - if frame_tick and (pending or press): flap = 1, pending <= 0;
  - else if press: pending <= 1;
  - flap = 0 on all other cycles.
  - flap is combinational from registered signals or registered; either way it must be exactly aligned with frame_tick.
- Simultaneous press and frame_tick: flap fires in that same cycle and pending stays 0.
- Multiple presses between two ticks collapse into a single flap.
- A press on the cycle after a tick waits for the following tick.
- flap_pending = pending register.
- Reset mid-operation clears the pending press and counter immediately, with no flap emitted. After release, the first frame_tick needs a real falling v_sync edge.
- Counter width: at DEBOUNCE_CYCLES-1 the counter never wraps. CNT_W too small is a configuration error; add a simulation-time check.

Test Plan (sim uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset release with v_sync held 1 and button 0 -> frame_tick, flap, button_level, flap_pending all 0 for 100 cycles.
- Button glitch: 0->1 for 3 cycles, then 0 -> button_level stays 0. Then held 1 for 10 cycles -> button_level = 1 exactly 2+4 cycles after the pin rose; flap_pending = 1 the following cycle.
- v_sync falls at cycle T with pending = 1 -> frame_tick = flap = 1 at cycle T+3 only, then flap_pending = 0. A second v_sync falling edge with no press -> frame_tick = 1, flap = 0.
- Three clean presses (each held 8 cycles, released 8 cycles) within one frame -> exactly one flap at the next frame_tick.
- Press edge landing on the same cycle as frame_tick -> flap = 1 that cycle, flap_pending never asserts.
- rst_n asserted while flap_pending = 1 -> flap_pending = 0 asynchronously. After release, next v_sync falling edge gives frame_tick = 1, flap = 0.

Source files
------------

// File: rtl/flap_if.sv
// Button / v_sync / control-pulse bundle between the input-conditioning stage
// and the game logic that consumes its frame-aligned pulses.
interface flap_if;
    logic button_raw;
    logic v_sync;
    logic button_level;
    logic frame_tick;
    logic flap;
    logic flap_pending;

    modport master (
        output button_raw,
        output v_sync,
        input  button_level,
        input  frame_tick,
        input  flap,
        input  flap_pending
    );

    modport slave (
        input  button_raw,
        input  v_sync,
        output button_level,
        output frame_tick,
        output flap,
        output flap_pending
    );
endinterface

// File: rtl/flap_input_cond.sv
// Input conditioning for the flappy-bird controller: synchronises and debounces
// the button, detects v_sync falling edges and issues frame-aligned flap pulses.
module flap_input_cond #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic   clk,
    input  logic   rst_n,
    flap_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // A counter too narrow for the debounce span would wrap and never accept a level.
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $fatal(1, "flap_input_cond: CNT_W too small for DEBOUNCE_CYCLES");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "flap_input_cond: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic [SYNC_STAGES-1:0] vs_sync_q, vs_sync_d;
    logic                   btn_s;
    logic                   vs_s;
    logic                   vs_dly_q, vs_dly_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   frame_tick_q, frame_tick_d;
    logic                   pending_q, pending_d;
    logic                   flap_s;

    assign btn_s = btn_sync_q[SYNC_STAGES-1];
    assign vs_s  = vs_sync_q[SYNC_STAGES-1];

    // Synchroniser shift and v_sync falling-edge detection.
    always_comb begin
        btn_sync_d   = {btn_sync_q[SYNC_STAGES-2:0], bus.button_raw};
        vs_sync_d    = {vs_sync_q[SYNC_STAGES-2:0], bus.v_sync};
        vs_dly_d     = vs_s;
        frame_tick_d = vs_dly_q & ~vs_s;
    end

    // Debounce: a new level must survive DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (btn_s == level_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            level_d = btn_s;
            cnt_d   = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        press_d = level_d & ~level_q;
    end

    // Pending latch: a tick consumes any captured press, otherwise a press is held.
    always_comb begin
        flap_s    = 1'b0;
        pending_d = pending_q;
        if (frame_tick_q && (pending_q || press_q)) begin
            flap_s    = 1'b1;
            pending_d = 1'b0;
        end else if (press_q) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // State registers; v_sync path resets to its idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q   <= {SYNC_STAGES{1'b0}};
            vs_sync_q    <= {SYNC_STAGES{1'b1}};
            vs_dly_q     <= 1'b1;
            cnt_q        <= CNT_ZERO;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            btn_sync_q   <= btn_sync_d;
            vs_sync_q    <= vs_sync_d;
            vs_dly_q     <= vs_dly_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            press_q      <= press_d;
            frame_tick_q <= frame_tick_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.button_level = level_q;
    assign bus.frame_tick   = frame_tick_q;
    assign bus.flap         = flap_s;
    assign bus.flap_pending = pending_q;

endmodule

// File: tb/tb_flap_input_cond.sv
// Directed, table-driven bench for flap_input_cond (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_flap_input_cond;

    typedef struct {
        logic b;
        logic v;
        logic lvl;
        logic tick;
        logic flap;
        logic pend;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t tbl[$];

    flap_if bus_if ();

    flap_input_cond #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic b, v, l, t, f, p);
        vec_t e;
        e.b = b; e.v = v; e.lvl = l; e.tick = t; e.flap = f; e.pend = p;
        tbl.push_back(e);
    endfunction

    function automatic void add_n(input int n, input logic b, v, l, t, f, p);
        for (int k = 0; k < n; k++) add(b, v, l, t, f, p);
    endfunction

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Entered on a negedge: drive inputs, let one posedge pass, check on the next negedge.
    task automatic apply(input logic b, v, l, t, f, p, input int idx);
        bus_if.button_raw = b;
        bus_if.v_sync     = v;
        @(negedge clk);
        check("button_level", idx, bus_if.button_level, l);
        check("frame_tick",   idx, bus_if.frame_tick,   t);
        check("flap",         idx, bus_if.flap,         f);
        check("flap_pending", idx, bus_if.flap_pending, p);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Idle after reset.
        add_n(100, 0, 1, 0, 0, 0, 0);
        // 3-cycle glitch stops one count short of acceptance.
        add_n(3, 1, 1, 0, 0, 0, 0);
        add_n(6, 0, 1, 0, 0, 0, 0);
        // Held press: level after 2+4 cycles, pending one cycle later.
        add_n(5, 1, 1, 0, 0, 0, 0);
        add  (1, 1, 1, 0, 0, 0);
        add_n(4, 1, 1, 1, 0, 0, 1);
        // Release debounces too but leaves the pending press alone.
        add_n(5, 0, 1, 1, 0, 0, 1);
        add_n(3, 0, 1, 0, 0, 0, 1);
        // v_sync falls with a pending press: tick and flap together, 3 cycles later.
        add_n(2, 0, 0, 0, 0, 0, 1);
        add  (0, 0, 0, 1, 1, 1);
        add_n(3, 0, 0, 0, 0, 0, 0);
        add_n(5, 0, 1, 0, 0, 0, 0);
        // Second falling edge with nothing pending: tick only.
        add_n(2, 0, 0, 0, 0, 0, 0);
        add  (0, 0, 0, 1, 0, 0);
        add_n(3, 0, 0, 0, 0, 0, 0);
        add_n(5, 0, 1, 0, 0, 0, 0);
        // Three presses in one frame collapse into one flap.
        for (int n = 0; n < 3; n++) begin
            add_n(5, 1, 1, 0, 0, 0, (n != 0));
            add  (1, 1, 1, 0, 0, (n != 0));
            add_n(2, 1, 1, 1, 0, 0, 1);
            add_n(5, 0, 1, 1, 0, 0, 1);
            add_n(3, 0, 1, 0, 0, 0, 1);
        end
        add_n(2, 0, 0, 0, 0, 0, 1);
        add  (0, 0, 0, 1, 1, 1);
        add_n(3, 0, 0, 0, 0, 0, 0);
        add_n(5, 0, 1, 0, 0, 0, 0);
        // Press edge on the very tick cycle: flap now, pending never set.
        add_n(3, 1, 1, 0, 0, 0, 0);
        add_n(2, 1, 0, 0, 0, 0, 0);
        add  (1, 0, 1, 1, 1, 0);
        add_n(4, 1, 0, 1, 0, 0, 0);
        add_n(3, 1, 1, 1, 0, 0, 0);
        add_n(5, 0, 1, 1, 0, 0, 0);
        add_n(3, 0, 1, 0, 0, 0, 0);
        // Press one cycle after a tick waits for the following tick.
        add_n(2, 1, 1, 0, 0, 0, 0);
        add_n(2, 1, 0, 0, 0, 0, 0);
        add  (1, 0, 0, 1, 0, 0);
        add  (1, 0, 1, 0, 0, 0);
        add_n(4, 1, 0, 1, 0, 0, 1);
        add_n(4, 1, 1, 1, 0, 0, 1);
        add_n(2, 1, 0, 1, 0, 0, 1);
        add  (1, 0, 1, 1, 1, 1);
        add_n(3, 1, 0, 1, 0, 0, 0);
        add_n(3, 1, 1, 1, 0, 0, 0);
        add_n(5, 0, 1, 1, 0, 0, 0);
        add_n(3, 0, 1, 0, 0, 0, 0);
        // Build up a pending press for the mid-operation reset.
        add_n(5, 1, 1, 0, 0, 0, 0);
        add  (1, 1, 1, 0, 0, 0);
        add_n(2, 1, 1, 1, 0, 0, 1);

        rst_n             = 1'b0;
        bus_if.button_raw = 1'b0;
        bus_if.v_sync     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_button_level", -1, bus_if.button_level, 1'b0);
        check("rst_frame_tick",   -1, bus_if.frame_tick,   1'b0);
        check("rst_flap",         -1, bus_if.flap,         1'b0);
        check("rst_flap_pending", -1, bus_if.flap_pending, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].b, tbl[i].v, tbl[i].lvl, tbl[i].tick, tbl[i].flap, tbl[i].pend, i);
        end

        // Asynchronous reset while a press is pending.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pending", 1000, bus_if.flap_pending, 1'b0);
        check("async_rst_level",   1000, bus_if.button_level, 1'b0);
        check("async_rst_flap",    1000, bus_if.flap,         1'b0);
        @(negedge clk);
        check("async_rst_tick",    1001, bus_if.frame_tick,   1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 0, 0, 0, 2000 + i);
        for (int i = 0; i < 2; i++) apply(0, 0, 0, 0, 0, 0, 2010 + i);
        apply(0, 0, 0, 1, 0, 0, 2012);
        for (int i = 0; i < 2; i++) apply(0, 0, 0, 0, 0, 0, 2020 + i);
        for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0, 0, 2030 + i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
